m_reg_file: RTL



---
 rtl/m_reg_file_pkg.sv | 32 +++
 rtl/m_reg_file_if.sv | 25 ++
 rtl/m_reg_file_wr_pipe.sv | 45 ++++
 rtl/m_reg_file.sv | 88 ++++++++
 4 files changed

// File: rtl/m_reg_file_pkg.sv
// Shared widths, write-request record and request builder for the m_reg_file
// register file and its write pipeline.
package m_reg_file_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    localparam wr_req_t WR_REQ_IDLE = '{valid: 1'b0, addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};

    function automatic wr_req_t make_req(input logic              we,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
        wr_req_t req;
        req = WR_REQ_IDLE;
        if (we) begin
            req.valid = 1'b1;
            req.addr  = addr;
            req.data  = data;
        end else begin
            req = WR_REQ_IDLE;
        end
        return req;
    endfunction

endpackage

// File: rtl/m_reg_file_if.sv
// Register-file bus: the datapath (master) drives write and read addresses,
// the register file (slave) returns both operands and the pending flag.
interface m_reg_file_if;
    import m_reg_file_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_address;
    logic              write;
    logic [ADDR_W-1:0] out1_address;
    logic [ADDR_W-1:0] out2_address;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic              wr_pending;

    modport master (
        output in_data, in_address, write, out1_address, out2_address,
        input  out1, out2, wr_pending
    );

    modport slave (
        input  in_data, in_address, write, out1_address, out2_address,
        output out1, out2, wr_pending
    );

endinterface

// File: rtl/m_reg_file_wr_pipe.sv
// m_wr_pipe: DEPTH-stage delay line of write requests with asynchronous clear.
// o_commit is the request that lands in the array at the coming edge.
module m_wr_pipe
    import m_reg_file_pkg::*;
#(
    parameter int DEPTH = 0,
    parameter int SLOTS = (DEPTH > 0) ? DEPTH : 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  wr_req_t i_req,
    output wr_req_t o_commit,
    output wr_req_t o_stage [SLOTS]
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero-depth pipe: the sampled request commits at its own edge
            logic w_unused_clk;
            assign w_unused_clk = i_clk ^ i_rst;
            assign o_commit     = i_req;
            assign o_stage[0]   = WR_REQ_IDLE;
        end else begin : g_stages
            wr_req_t r_stage [DEPTH];

            // Shift every edge; bubbles travel like any other entry
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        r_stage[s] <= WR_REQ_IDLE;
                    end
                end else begin
                    r_stage[0] <= i_req;
                    for (int s = 1; s < DEPTH; s++) begin
                        r_stage[s] <= r_stage[s-1];
                    end
                end
            end

            assign o_commit = r_stage[DEPTH-1];
            assign o_stage  = r_stage;
        end
    endgenerate

endmodule

// File: rtl/m_reg_file.sv
// m_reg_file: 8 x 8-bit register file with combinational reads and a WR_LAT
// write-back pipeline. Define REGFILE_FORWARD_EN to let reads see pending writes.
module m_reg_file
    import m_reg_file_pkg::*;
#(
    parameter int WR_LAT = 1
) (
    input logic         i_clk,
    input logic         i_rst,
    m_reg_file_if.slave if_bus
);

    localparam int PIPE_DEPTH = WR_LAT - 1;
    localparam int PIPE_SLOTS = (PIPE_DEPTH > 0) ? PIPE_DEPTH : 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    wr_req_t           w_req;
    wr_req_t           w_commit;
    wr_req_t           w_stage [PIPE_SLOTS];
    logic              w_pending;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_req = make_req(if_bus.write & ~i_rst, if_bus.in_address, if_bus.in_data);

    m_wr_pipe #(
        .DEPTH (PIPE_DEPTH),
        .SLOTS (PIPE_SLOTS)
    ) u_wr_pipe (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (w_req),
        .o_commit (w_commit),
        .o_stage  (w_stage)
    );

    // Storage array: only the oldest valid request ever writes it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= {DATA_W{1'b0}};
            end
        end else if (w_commit.valid) begin
            r_regs[w_commit.addr] <= w_commit.data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Any valid stage means a sampled write is still in flight
    always_comb begin
        w_pending = 1'b0;
        for (int s = 0; s < PIPE_SLOTS; s++) begin
            w_pending = w_pending | w_stage[s].valid;
        end
    end

`ifdef REGFILE_FORWARD_EN
    // Scan oldest to youngest so the youngest matching stage wins
    always_comb begin
        w_rd1 = r_regs[if_bus.out1_address];
        w_rd2 = r_regs[if_bus.out2_address];
        for (int s = PIPE_SLOTS - 1; s >= 0; s--) begin
            w_rd1 = (w_stage[s].valid && (w_stage[s].addr == if_bus.out1_address)) ? w_stage[s].data : w_rd1;
            w_rd2 = (w_stage[s].valid && (w_stage[s].addr == if_bus.out2_address)) ? w_stage[s].data : w_rd2;
        end
    end
`else
    logic w_unused_stage;

    assign w_rd1 = r_regs[if_bus.out1_address];
    assign w_rd2 = r_regs[if_bus.out2_address];

    // Stage address/data only matter to forwarding
    always_comb begin
        w_unused_stage = 1'b0;
        for (int s = 0; s < PIPE_SLOTS; s++) begin
            w_unused_stage = w_unused_stage ^ (^{w_stage[s].addr, w_stage[s].data});
        end
    end
`endif

    assign if_bus.out1       = i_rst ? {DATA_W{1'b0}} : w_rd1;
    assign if_bus.out2       = i_rst ? {DATA_W{1'b0}} : w_rd2;
    assign if_bus.wr_pending = w_pending & ~i_rst;

endmodule
